// File: rtl/priority_resolver_fsm.sv
// Priority resolver and in-service tracker: ranks pending requests against the ISR,
// runs the two-pulse INTA handshake and applies OCW2 EOI/rotation commands.
module priority_resolver_fsm #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               special_mask,
  input  logic               aeoi,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_op,
  input  logic [IDX_W-1:0]   cmd_level,
  input  logic               inta,
  output logic               int_req,
  output logic [NUM_IRQ-1:0] irr_clr,
  output logic               vector_valid,
  output logic [IDX_W-1:0]   vector_idx,
  output logic [NUM_IRQ-1:0] isr,
  output logic [IDX_W-1:0]   lowest_prio
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK1 = 2'd2
  } state_t;

  localparam logic [IDX_W:0]   N_W   = (IDX_W+1)'(NUM_IRQ);
  localparam logic [IDX_W:0]   ONE_W = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] TOP_L = IDX_W'(NUM_IRQ - 1);

  state_t             state_q;
  logic               int_req_q;
  logic [NUM_IRQ-1:0] irr_clr_q;
  logic               vector_valid_q;
  logic [IDX_W-1:0]   vector_idx_q;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [IDX_W-1:0]   lowest_q, lowest_d;
  logic               rot_q, rot_d;
  logic [IDX_W-1:0]   win_q;
  logic               spur_q;

  logic [NUM_IRQ-1:0] req_vec, blk_vec;
  logic               cand_vld, blk_vld, eligible;
  logic [IDX_W-1:0]   cand_idx, blk_idx;
  logic [IDX_W:0]     cand_rank, blk_rank, r;
  logic [NUM_IRQ-1:0] cand_oh, blk_oh, lvl_oh, win_oh;
  logic               lvl_ok, cmd_go, ack1, ack2;

  // Wrap handled by compare so non-power-of-two NUM_IRQ ranks correctly.
  function automatic logic [IDX_W:0] rank_of(input logic [IDX_W:0] i, input logic [IDX_W-1:0] lo);
    logic [IDX_W:0] lo_e;
    lo_e = {1'b0, lo};
    if (i > lo_e) rank_of = i - lo_e - ONE_W;
    else          rank_of = i + N_W - lo_e - ONE_W;
  endfunction

  assign req_vec = irr & ~imr;
  assign blk_vec = isr_q & ~(special_mask ? imr : '0);

  always_comb begin
    cand_vld  = 1'b0;
    cand_idx  = '0;
    cand_rank = '0;
    blk_vld   = 1'b0;
    blk_idx   = '0;
    blk_rank  = '0;
    r         = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      r = rank_of((IDX_W+1)'(i), lowest_q);
      if (req_vec[i] && (!cand_vld || r < cand_rank)) begin
        cand_vld  = 1'b1;
        cand_idx  = IDX_W'(i);
        cand_rank = r;
      end
      if (blk_vec[i] && (!blk_vld || r < blk_rank)) begin
        blk_vld  = 1'b1;
        blk_idx  = IDX_W'(i);
        blk_rank = r;
      end
    end
  end

  assign eligible = cand_vld && (!blk_vld || cand_rank < blk_rank);

  assign cand_oh = NUM_IRQ'(1) << cand_idx;
  assign blk_oh  = NUM_IRQ'(1) << blk_idx;
  assign lvl_oh  = NUM_IRQ'(1) << cmd_level;
  assign win_oh  = NUM_IRQ'(1) << win_q;

  assign lvl_ok = {1'b0, cmd_level} < N_W;
  assign cmd_go = cmd_valid && lvl_ok;
  assign ack1   = (state_q == REQ) && inta;
  assign ack2   = (state_q == ACK1) && inta;

  // Command acts on pre-cycle state; AEOI rotation then overrides, and an INTA set wins last.
  always_comb begin
    isr_d    = isr_q;
    lowest_d = lowest_q;
    rot_d    = rot_q;
    if (cmd_go) begin
      case (cmd_op)
        3'b001: if (blk_vld) isr_d = isr_d & ~blk_oh;
        3'b011: isr_d = isr_d & ~lvl_oh;
        3'b101: if (blk_vld) begin
          isr_d    = isr_d & ~blk_oh;
          lowest_d = blk_idx;
        end
        3'b111: begin
          isr_d    = isr_d & ~lvl_oh;
          lowest_d = cmd_level;
        end
        3'b110: lowest_d = cmd_level;
        3'b100: rot_d = 1'b1;
        3'b000: rot_d = 1'b0;
        default: ;
      endcase
    end
    if (ack2 && aeoi && !spur_q) begin
      isr_d = isr_d & ~win_oh;
      if (rot_q) lowest_d = win_q;
    end
    if (ack1 && cand_vld) isr_d = isr_d | cand_oh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      int_req_q      <= 1'b0;
      irr_clr_q      <= '0;
      vector_valid_q <= 1'b0;
      vector_idx_q   <= '0;
      isr_q          <= '0;
      lowest_q       <= TOP_L;
      rot_q          <= 1'b0;
      win_q          <= '0;
      spur_q         <= 1'b0;
    end else begin
      irr_clr_q      <= '0;
      vector_valid_q <= 1'b0;
      isr_q          <= isr_d;
      lowest_q       <= lowest_d;
      rot_q          <= rot_d;
      case (state_q)
        IDLE: begin
          if (eligible) begin
            state_q   <= REQ;
            int_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (inta) begin
            state_q   <= ACK1;
            int_req_q <= 1'b0;
            if (cand_vld) begin
              win_q     <= cand_idx;
              spur_q    <= 1'b0;
              irr_clr_q <= cand_oh;
            end else begin
              win_q  <= TOP_L;
              spur_q <= 1'b1;
            end
          end else if (!eligible) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
          end
        end
        ACK1: begin
          if (inta) begin
            state_q        <= IDLE;
            vector_valid_q <= 1'b1;
            vector_idx_q   <= win_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign int_req      = int_req_q;
  assign irr_clr      = irr_clr_q;
  assign vector_valid = vector_valid_q;
  assign vector_idx   = vector_idx_q;
  assign isr          = isr_q;
  assign lowest_prio  = lowest_q;

endmodule

// File: tb/tb_priority_resolver_fsm.sv
// Directed bench for priority_resolver_fsm: an 8-line and a 5-line instance.
module tb_priority_resolver_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] irr8, imr8, clr8, isr8;
  logic       sm8, aeoi8, cv8, inta8, ir8, vv8;
  logic [2:0] op8, lvl8, vi8, lo8;

  logic [4:0] irr5, imr5, clr5, isr5;
  logic       sm5, aeoi5, cv5, inta5, ir5, vv5;
  logic [2:0] op5, lvl5, vi5, lo5;

  int n_vec = 0;
  int n_err = 0;

  priority_resolver_fsm #(.NUM_IRQ(8)) u8 (
    .clk(clk), .reset(rst), .irr(irr8), .imr(imr8), .special_mask(sm8), .aeoi(aeoi8),
    .cmd_valid(cv8), .cmd_op(op8), .cmd_level(lvl8), .inta(inta8),
    .int_req(ir8), .irr_clr(clr8), .vector_valid(vv8), .vector_idx(vi8),
    .isr(isr8), .lowest_prio(lo8)
  );

  priority_resolver_fsm #(.NUM_IRQ(5)) u5 (
    .clk(clk), .reset(rst), .irr(irr5), .imr(imr5), .special_mask(sm5), .aeoi(aeoi5),
    .cmd_valid(cv5), .cmd_op(op5), .cmd_level(lvl5), .inta(inta5),
    .int_req(ir5), .irr_clr(clr5), .vector_valid(vv5), .vector_idx(vi5),
    .isr(isr5), .lowest_prio(lo5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit later and strobes drop.
  task automatic tick();
    @(posedge clk);
    #1;
    inta8 = 1'b0; cv8 = 1'b0;
    inta5 = 1'b0; cv5 = 1'b0;
  endtask

  task automatic cmd8(input logic [2:0] op, input logic [2:0] lvl);
    cv8 = 1'b1; op8 = op; lvl8 = lvl;
    tick();
  endtask

  task automatic cmd5(input logic [2:0] op, input logic [2:0] lvl);
    cv5 = 1'b1; op5 = op; lvl5 = lvl;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    irr8 = '0; imr8 = '0; sm8 = 0; aeoi8 = 0; cv8 = 0; op8 = '0; lvl8 = '0; inta8 = 0;
    irr5 = '0; imr5 = '0; sm5 = 0; aeoi5 = 0; cv5 = 0; op5 = '0; lvl5 = '0; inta5 = 0;
    tick(); tick();
    chk("rst_int_req", ir8, 0);
    chk("rst_irr_clr", clr8, 0);
    chk("rst_vvalid", vv8, 0);
    chk("rst_vidx", vi8, 0);
    chk("rst_isr", isr8, 0);
    chk("rst_lowest8", lo8, 7);
    chk("rst_lowest5", lo5, 4);
    rst = 1'b0;

    // Basic handshake: 3 outranks 5 with lowest=7
    irr8 = 8'h28; tick();
    chk("t1_int_req", ir8, 1);
    inta8 = 1; tick();
    chk("t1_isr", isr8, 8'h08);
    chk("t1_irr_clr", clr8, 8'h08);
    chk("t1_int_req_drop", ir8, 0);
    irr8 = 8'h20;
    inta8 = 1; tick();
    chk("t1_vvalid", vv8, 1);
    chk("t1_vidx", vi8, 3);
    chk("t1_clr_pulse", clr8, 0);
    tick();
    chk("t1_blocked5", ir8, 0);
    chk("t1_vvalid_pulse", vv8, 0);

    // Nesting: 1 outranks in-service 3, 4 does not until EOI
    irr8 = 8'h02; tick();
    chk("t2_nest_req", ir8, 1);
    irr8 = 8'h10; tick();
    chk("t2_drop_req", ir8, 0);
    tick();
    chk("t2_still_blocked", ir8, 0);
    cmd8(3'b001, 3'd0);
    chk("t2_ns_eoi_isr", isr8, 0);
    tick();
    chk("t2_after_eoi_req", ir8, 1);
    inta8 = 1; tick();
    chk("t2_isr4", isr8, 8'h10);
    irr8 = 8'h00;
    inta8 = 1; tick();
    chk("t2_vidx4", vi8, 4);
    cmd8(3'b011, 3'd4);
    chk("t2_spec_eoi", isr8, 0);

    // Rotate on non-specific EOI
    irr8 = 8'h04; tick();
    inta8 = 1; tick();
    irr8 = 8'h00;
    inta8 = 1; tick();
    chk("t3_vidx2", vi8, 2);
    chk("t3_isr_pre", isr8, 8'h04);
    cmd8(3'b101, 3'd0);
    chk("t3_rot_isr", isr8, 0);
    chk("t3_rot_lowest", lo8, 2);
    irr8 = 8'h0A; tick();
    chk("t3_req", ir8, 1);
    inta8 = 1; tick();
    chk("t3_isr8", isr8, 8'h08);
    irr8 = 8'h02;
    inta8 = 1; tick();
    chk("t3_vidx3", vi8, 3);
    irr8 = 8'h00;
    cmd8(3'b111, 3'd3);
    chk("t3_rs_isr", isr8, 0);
    chk("t3_rs_lowest", lo8, 3);

    // Spurious: request vanishes before first INTA
    irr8 = 8'h01; tick();
    chk("t5_req", ir8, 1);
    irr8 = 8'h00;
    inta8 = 1; tick();
    chk("t5_spur_isr", isr8, 0);
    chk("t5_spur_clr", clr8, 0);
    inta8 = 1; tick();
    chk("t5_spur_vv", vv8, 1);
    chk("t5_spur_vidx", vi8, 7);
    chk("t5_spur_isr2", isr8, 0);

    // Reset in the middle of the handshake
    irr8 = 8'h01; tick();
    inta8 = 1; tick();
    chk("t5_ack1_isr", isr8, 8'h01);
    irr8 = 8'h00;
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("t5_rst_int_req", ir8, 0);
    chk("t5_rst_clr", clr8, 0);
    chk("t5_rst_vv", vv8, 0);
    chk("t5_rst_vidx", vi8, 0);
    chk("t5_rst_isr", isr8, 0);
    chk("t5_rst_lowest", lo8, 7);
    inta8 = 1; tick();
    chk("t5_idle_inta", vv8, 0);

    // Special mask: masked in-service bit no longer blocks
    irr8 = 8'h01; tick();
    inta8 = 1; tick();
    irr8 = 8'h00;
    inta8 = 1; tick();
    chk("t6_vidx0", vi8, 0);
    imr8 = 8'h01; sm8 = 1; irr8 = 8'h04; tick();
    chk("t6_sm_req", ir8, 1);
    sm8 = 0; tick();
    chk("t6_nosm_drop", ir8, 0);
    sm8 = 1; tick();
    chk("t6_sm_req2", ir8, 1);

    // 5-line instance: AEOI with rotation, non-power-of-two wrap
    aeoi5 = 1;
    cmd5(3'b100, 3'd0);
    irr5 = 5'h01; tick();
    chk("t4_req", ir5, 1);
    inta5 = 1; tick();
    chk("t4_isr", isr5, 5'h01);
    chk("t4_clr", clr5, 5'h01);
    irr5 = 5'h00;
    inta5 = 1; tick();
    chk("t4_vv", vv5, 1);
    chk("t4_vidx", vi5, 0);
    chk("t4_aeoi_isr", isr5, 0);
    chk("t4_aeoi_lowest", lo5, 0);
    irr5 = 5'h11; tick();
    inta5 = 1; tick();
    chk("t4_wrap_isr", isr5, 5'h10);
    irr5 = 5'h00;
    inta5 = 1; tick();
    chk("t4_wrap_vidx", vi5, 4);
    chk("t4_wrap_lowest", lo5, 4);
    cmd5(3'b000, 3'd0);
    cmd5(3'b110, 3'd2);
    chk("t4_setp2", lo5, 2);
    cmd5(3'b110, 3'd4);
    chk("t4_setp4", lo5, 4);
    irr5 = 5'h11; tick();
    inta5 = 1; tick();
    irr5 = 5'h10;
    inta5 = 1; tick();
    chk("t4_top0_vidx", vi5, 0);
    chk("t4_norot_lowest", lo5, 4);
    chk("t4_norot_isr", isr5, 0);
    irr5 = 5'h00;
    tick(); tick(); tick();
    cmd5(3'b110, 3'd6);
    chk("t6_badlvl_setp", lo5, 4);
    cmd5(3'b111, 3'd7);
    chk("t6_badlvl_rot", lo5, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
